// File: rtl/score_accumulator.sv
// Sequential score accumulator: sums masked signed channel scores one channel per cycle.
// Optional build macro SCORE_CLAMP_EN saturates the result to the range 0..2^OUT_W-1.
module score_accumulator #(
   parameter int NUM_CH  = 8,
   parameter int SCORE_W = 4,
   parameter int OUT_W   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [NUM_CH*SCORE_W-1:0] scores,
   input  logic [NUM_CH-1:0]         ch_mask,
   output logic                      busy,
   output logic                      done,
   output logic [OUT_W-1:0]          sum
);

   localparam int IDX_W = $clog2(NUM_CH);
   localparam int ACC_W = SCORE_W + $clog2(NUM_CH) + 1;

   // Handshake: a start seen in IDLE is accepted on that rising edge; busy stays
   // high through ACCUM and DONE, and done is a one-cycle pulse while sum is new.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                    r_state;
   logic [NUM_CH*SCORE_W-1:0] r_scores;
   logic [NUM_CH-1:0]         r_mask;
   logic [IDX_W-1:0]          r_idx;
   logic signed [ACC_W-1:0]   r_acc;
   logic                      r_busy;
   logic                      r_done;
   logic [OUT_W-1:0]          r_sum;

   logic [SCORE_W-1:0]        w_ch [NUM_CH];
   logic signed [ACC_W-1:0]   w_term;
   logic signed [ACC_W-1:0]   w_next_acc;
   logic [OUT_W-1:0]          w_result;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_ch[k] = r_scores[k*SCORE_W +: SCORE_W];
   end

   always_comb begin
      w_term = '0;
      if (r_mask[r_idx]) begin
         w_term = ACC_W'($signed(w_ch[r_idx]));
      end
      w_next_acc = r_acc + w_term;
   end

`ifdef SCORE_CLAMP_EN
   localparam int EXT_W = (ACC_W > OUT_W + 1) ? ACC_W : OUT_W + 1;
   localparam logic [EXT_W-1:0] MAX_V = EXT_W'((2 ** OUT_W) - 1);

   // Negative totals floor at zero; large positive totals saturate at all-ones.
   always_comb begin
      if (w_next_acc[ACC_W-1]) begin
         w_result = '0;
      end else if (EXT_W'(w_next_acc) > MAX_V) begin
         w_result = '1;
      end else begin
         w_result = OUT_W'(w_next_acc);
      end
   end
`else
   assign w_result = OUT_W'(w_next_acc);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_scores <= '0;
         r_mask   <= '0;
         r_idx    <= '0;
         r_acc    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_sum    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_scores <= scores;
                  r_mask   <= ch_mask;
                  r_acc    <= '0;
                  r_idx    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               r_acc <= w_next_acc;
               if (r_idx == IDX_W'(NUM_CH - 1)) begin
                  r_sum   <= w_result;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator (default parameters); expectations follow SCORE_CLAMP_EN.
module tb_score_accumulator;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] scores;
   logic [7:0]  ch_mask;
   logic        busy;
   logic        done;
   logic [3:0]  sum;

   int n_tests = 0;
   int n_fail  = 0;

   score_accumulator #(.NUM_CH(8), .SCORE_W(4), .OUT_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .scores  (scores),
      .ch_mask (ch_mask),
      .busy    (busy),
      .done    (done),
      .sum     (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] sc;
      logic [7:0]  m;
      logic [3:0]  e_nc;
      logic [3:0]  e_cl;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [3:0] pick(input logic [3:0] e_nc, input logic [3:0] e_cl);
`ifdef SCORE_CLAMP_EN
      return e_cl;
`else
      return e_nc;
`endif
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   // One full operation: checks latency, busy length, result and post-done hold.
   task automatic run_op(input logic [31:0] sc, input logic [7:0] m, input logic [3:0] exp_s, input string nm);
      int lat;
      int busy_cnt;
      @(negedge clk);
      scores  = sc;
      ch_mask = m;
      start   = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      if (busy) busy_cnt++;
      chk({nm, "_latency"}, lat, 9);
      chk({nm, "_busy_cycles"}, busy_cnt, 9);
      chk({nm, "_sum"}, int'(sum), int'(exp_s));
      @(negedge clk);
      chk({nm, "_done_pulse_len"}, int'(done), 0);
      chk({nm, "_sum_hold"}, int'(sum), int'(exp_s));
   endtask

   // Counts busy/done activity over a quiet window where nothing should run.
   task automatic watch_idle(input int cycles, input string nm);
      int act;
      act = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (busy || done) act++;
      end
      chk({nm, "_idle"}, act, 0);
   endtask

   logic [3:0] exp_q[$];
   int         exp_cyc_q[$];

   initial begin
      // channel 7..0 one nibble each
      vecs[0] = '{32'h0001E00E, 8'hFF, 4'd13, 4'd0};   // total -3
      vecs[1] = '{32'h12102211, 8'hFF, 4'd10, 4'd10};  // total 10
      vecs[2] = '{32'h77777777, 8'hFF, 4'd8,  4'd15};  // total 56
      vecs[3] = '{32'h22021000, 8'h7F, 4'd5,  4'd5};   // ch7 masked, total 5
      vecs[4] = '{32'h77777777, 8'h00, 4'd0,  4'd0};   // all masked
      vecs[5] = '{32'h00000008, 8'h01, 4'd8,  4'd0};   // -8
      vecs[6] = '{32'h88888888, 8'hFF, 4'd0,  4'd0};   // -64
      vecs[7] = '{32'h12345678, 8'hAA, 4'd0,  4'd15};  // 1+3+5+7 = 16
      vecs[8] = '{32'h00000177, 8'hFF, 4'd15, 4'd15};  // exactly 15

      reset   = 1'b0;
      start   = 1'b0;
      scores  = '0;
      ch_mask = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_sum", int'(sum), 0);
      reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].sc, vecs[i].m, pick(vecs[i].e_nc, vecs[i].e_cl), $sformatf("vec%0d", i));
      end

      // Start pulse and new inputs while accumulating must not disturb the result.
      begin
         int lat;
         @(negedge clk);
         scores  = 32'h22021000;
         ch_mask = 8'h7F;
         start   = 1'b1;
         @(negedge clk);
         start = 1'b0;
         lat   = 1;
         while (!done && lat < 20) begin
            if (lat == 3) begin
               start   = 1'b1;
               scores  = 32'hFFFFFFFF;
               ch_mask = 8'hFF;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            lat++;
         end
         start = 1'b0;
         chk("midflight_latency", lat, 9);
         chk("midflight_sum", int'(sum), 5);
         watch_idle(11, "midflight_no_restart");
      end

      // Reset in the 4th ACCUM cycle aborts with no done pulse.
      begin
         int lat;
         @(negedge clk);
         scores  = 32'h12102211;
         ch_mask = 8'hFF;
         start   = 1'b1;
         @(negedge clk);
         start = 1'b0;
         lat   = 1;
         while (lat < 4) begin
            @(negedge clk);
            lat++;
         end
         reset = 1'b0;
         @(negedge clk);
         reset = 1'b1;
         chk("abort_busy", int'(busy), 0);
         chk("abort_done", int'(done), 0);
         chk("abort_sum", int'(sum), 0);
         watch_idle(12, "abort");
         run_op(32'h12102211, 8'hFF, 4'd10, "after_abort");
      end

      // Reset and start together: reset wins.
      @(negedge clk);
      reset   = 1'b0;
      start   = 1'b1;
      scores  = 32'h77777777;
      ch_mask = 8'hFF;
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      chk("rst_start_sum", int'(sum), 0);
      watch_idle(12, "rst_start");

      // Start held high 30 cycles: back-to-back operations every 10 cycles.
      begin
         int n_done;
         exp_q.push_back(pick(vecs[1].e_nc, vecs[1].e_cl));
         exp_q.push_back(pick(vecs[3].e_nc, vecs[3].e_cl));
         exp_q.push_back(pick(vecs[2].e_nc, vecs[2].e_cl));
         exp_cyc_q.push_back(9);
         exp_cyc_q.push_back(19);
         exp_cyc_q.push_back(29);
         n_done = 0;
         @(negedge clk);
         scores  = vecs[1].sc;
         ch_mask = vecs[1].m;
         start   = 1'b1;
         for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
               scores  = vecs[3].sc;
               ch_mask = vecs[3].m;
            end
            if (c == 11) begin
               scores  = vecs[2].sc;
               ch_mask = vecs[2].m;
            end
            if (c == 30) start = 1'b0;
            if (done) begin
               n_done++;
               if (exp_q.size() > 0) begin
                  chk($sformatf("b2b_cycle%0d", n_done), c, exp_cyc_q.pop_front());
                  chk($sformatf("b2b_sum%0d", n_done), int'(sum), int'(exp_q.pop_front()));
               end else begin
                  chk("b2b_extra_done", c, 0);
               end
            end
         end
         start = 1'b0;
         chk("b2b_done_count", n_done, 3);
         chk("b2b_queue_left", exp_q.size(), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
